// File: rtl/fifo_async_prog_pkg.sv
// fifo_async_pkg: Gray/binary pointer helpers and read-mode constants for fifo_async_prog
package fifo_async_pkg;

  localparam int PTR_MAX   = 32;
  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly because leading zeros do not disturb the prefix XOR
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_async_prog_gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchronizer for Gray-coded pointers and the reset copy
module gray_ptr_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the bus through STAGES flops; a Gray source changes at most one bit per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_prog.sv
// fifo_async_prog: dual-clock FIFO with programmable thresholds, occupancy, sticky errors and optional FWFT
module fifo_async_prog
  import fifo_async_pkg::*;
#(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             w_en,
  output logic             w_full,
  output logic             w_afull,
  input  logic [ASIZE:0]   w_af_thr,
  output logic [ASIZE:0]   wuse,
  output logic             w_ovf,
  input  logic             rclk,
  output logic [DSIZE-1:0] rdata,
  input  logic             r_en,
  output logic             r_empty,
  output logic             r_aempty,
  input  logic [ASIZE:0]   r_ae_thr,
  output logic             r_ok,
  output logic [ASIZE:0]   ruse,
  output logic             r_udf
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d, wuse_q, wuse_d, rgray_s;
  logic           w_ovf_q, w_ovf_d, w_inc;

  logic [ASIZE:0]   rbin_q, rbin_d, rgray_q, rgray_d, ruse_q, ruse_d, wgray_s;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d, r_udf_q, r_udf_d, r_load, r_fifo_empty, rrst_n;

  gray_ptr_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
    .clk(rclk), .rst_n(1'b1), .d_i(rst_n), .q_o(rrst_n)
  );

  gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_w2r_sync (
    .clk(rclk), .rst_n(rrst_n), .d_i(wgray_q), .q_o(wgray_s)
  );

  gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_r2w_sync (
    .clk(wclk), .rst_n(rst_n), .d_i(rgray_q), .q_o(rgray_s)
  );

  // Write side: full detect from registered pointers, pointer advance, occupancy, overflow
  always_comb begin
    w_full  = wgray_q == {~rgray_s[ASIZE:ASIZE-1], rgray_s[ASIZE-2:0]};
    w_inc   = w_en & ~w_full;
    wbin_d  = wbin_q + PW'(w_inc);
    wgray_d = PW'(bin2gray(PTR_MAX'(wbin_d)));
    wuse_d  = wbin_d - PW'(gray2bin(PTR_MAX'(rgray_s)));
    w_ovf_d = w_ovf_q | (w_en & w_full);
  end

  // Write-domain state registers
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wuse_q  <= '0;
      w_ovf_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wuse_q  <= wuse_d;
      w_ovf_q <= w_ovf_d;
    end
  end

  // Storage array, written only on accepted writes
  always_ff @(posedge wclk) begin
    if (rst_n && w_inc) mem[wbin_q[ASIZE-1:0]] <= wdata;
  end

  // Read side: valid_q is r_ok in standard mode and the prefetch-full flag in FWFT mode
  always_comb begin
    r_fifo_empty = rgray_q == wgray_s;
    r_empty      = (FWFT == FWFT_FALL) ? ~valid_q : r_fifo_empty;
    r_load       = (FWFT == FWFT_FALL) ? (~r_fifo_empty & (~valid_q | r_en)) : (r_en & ~r_fifo_empty);
    valid_d      = (FWFT == FWFT_FALL) ? (r_load | (valid_q & ~r_en)) : r_load;
    rbin_d       = rbin_q + PW'(r_load);
    rgray_d      = PW'(bin2gray(PTR_MAX'(rbin_d)));
    rdata_d      = r_load ? mem[rbin_q[ASIZE-1:0]] : rdata_q;
    ruse_d       = PW'(gray2bin(PTR_MAX'(wgray_s))) - rbin_d + ((FWFT == FWFT_FALL) ? PW'(valid_d) : '0);
    r_udf_d      = r_udf_q | (r_en & r_empty);
  end

  // Read-domain state registers, reset by the synchronized reset copy
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      ruse_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      r_udf_q <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      ruse_q  <= ruse_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      r_udf_q <= r_udf_d;
    end
  end

  assign w_afull  = wuse_q >= w_af_thr;
  assign wuse     = wuse_q;
  assign w_ovf    = w_ovf_q;
  assign rdata    = rdata_q;
  assign r_aempty = ruse_q <= r_ae_thr;
  assign r_ok     = valid_q;
  assign ruse     = ruse_q;
  assign r_udf    = r_udf_q;

endmodule

// File: tb/tb_fifo_async_prog.sv
// tb_fifo_async_prog: scoreboard bench for standard and FWFT instances of fifo_async_prog
module tb_fifo_async_prog;

  localparam int SS = 2;

  logic       wclk = 0, rclk = 0, rst_n = 0;
  logic [7:0] wdata = 0, wdata_f = 0;
  logic       w_en = 0, w_en_f = 0, r_en = 0, r_en_f = 0;
  logic [5:0] w_af_thr = 6'd28, w_af_thr_f = 6'd0, r_ae_thr = 6'd2, r_ae_thr_f = 6'd2;

  logic       w_full, w_afull, w_ovf, r_empty, r_aempty, r_ok, r_udf;
  logic [5:0] wuse, ruse;
  logic [7:0] rdata;
  logic       w_full_f, w_afull_f, w_ovf_f, r_empty_f, r_aempty_f, r_ok_f, r_udf_f;
  logic [5:0] wuse_f, ruse_f;
  logic [7:0] rdata_f;

  int errors = 0, checks = 0;
  logic [7:0] exp_q[$], exp_f[$];

  always #5 wclk = ~wclk;
  initial begin #1; forever #3 rclk = ~rclk; end

  fifo_async_prog #(.DSIZE(8), .ASIZE(5), .SYNC_STAGES(SS), .FWFT(0)) dut (
    .wclk(wclk), .rst_n(rst_n), .wdata(wdata), .w_en(w_en), .w_full(w_full), .w_afull(w_afull),
    .w_af_thr(w_af_thr), .wuse(wuse), .w_ovf(w_ovf), .rclk(rclk), .rdata(rdata), .r_en(r_en),
    .r_empty(r_empty), .r_aempty(r_aempty), .r_ae_thr(r_ae_thr), .r_ok(r_ok), .ruse(ruse), .r_udf(r_udf)
  );

  fifo_async_prog #(.DSIZE(8), .ASIZE(5), .SYNC_STAGES(SS), .FWFT(1)) dut_f (
    .wclk(wclk), .rst_n(rst_n), .wdata(wdata_f), .w_en(w_en_f), .w_full(w_full_f), .w_afull(w_afull_f),
    .w_af_thr(w_af_thr_f), .wuse(wuse_f), .w_ovf(w_ovf_f), .rclk(rclk), .rdata(rdata_f), .r_en(r_en_f),
    .r_empty(r_empty_f), .r_aempty(r_aempty_f), .r_ae_thr(r_ae_thr_f), .r_ok(r_ok_f), .ruse(ruse_f), .r_udf(r_udf_f)
  );

  task automatic test_reset;
    rst_n = 0;
    repeat (4) @(posedge wclk);
    #1 rst_n = 1;
    repeat (6) @(posedge wclk);
    #1;
    checks++;
    if ({w_full, w_afull, w_ovf, wuse} !== {1'b0, 1'b0, 1'b0, 6'd0}) begin
      errors++; $display("FAIL reset_wr got %b exp %b", {w_full, w_afull, w_ovf, wuse}, 9'b0);
    end
    checks++;
    if ({w_full_f, w_afull_f, w_ovf_f, wuse_f} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      errors++; $display("FAIL reset_wr_fwft got %b exp %b", {w_full_f, w_afull_f, w_ovf_f, wuse_f}, 9'b010000000);
    end
    @(posedge rclk); #1;
    checks++;
    if ({r_empty, r_aempty, r_ok, r_udf, ruse, rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'd0}) begin
      errors++; $display("FAIL reset_rd got %b exp %b", {r_empty, r_aempty, r_ok, r_udf, ruse, rdata}, {4'b1100, 14'd0});
    end
    checks++;
    if ({r_empty_f, r_aempty_f, r_ok_f, r_udf_f, ruse_f} !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd0}) begin
      errors++; $display("FAIL reset_rd_fwft got %b exp %b", {r_empty_f, r_aempty_f, r_ok_f, r_udf_f, ruse_f}, {4'b1100, 6'd0});
    end
  endtask

  task automatic test_fill;
    @(posedge wclk); #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (w_full !== 1'b0) begin errors++; $display("FAIL fill_not_full i=%0d got %b exp 0", i, w_full); end
      w_en = 1; wdata = 8'(i);
      exp_q.push_back(8'(i));
      @(posedge wclk); #1;
      checks++;
      if ({wuse, w_afull} !== {6'(i + 1), 1'(i + 1 >= 28)}) begin
        errors++; $display("FAIL fill_use i=%0d got wuse=%0d afull=%b exp wuse=%0d afull=%b", i, wuse, w_afull, i + 1, i + 1 >= 28);
      end
    end
    w_en = 0;
    checks++;
    if ({w_full, w_afull, w_ovf, wuse} !== {1'b1, 1'b1, 1'b0, 6'd32}) begin
      errors++; $display("FAIL full_state got %b exp %b", {w_full, w_afull, w_ovf, wuse}, {3'b110, 6'd32});
    end
    w_en = 1; wdata = 8'hAA;
    @(posedge wclk); #1;
    w_en = 0;
    checks++;
    if ({w_full, w_ovf, wuse} !== {1'b1, 1'b1, 6'd32}) begin
      errors++; $display("FAIL overflow got %b exp %b", {w_full, w_ovf, wuse}, {2'b11, 6'd32});
    end
  endtask

  task automatic test_drain;
    int got, issued, cyc;
    logic [7:0] e;
    got = 0; issued = 0; cyc = 0;
    repeat (4) @(posedge rclk); #1;
    checks++;
    if ({r_empty, r_aempty, ruse} !== {1'b0, 1'b0, 6'd32}) begin
      errors++; $display("FAIL drain_start got %b exp %b", {r_empty, r_aempty, ruse}, {2'b00, 6'd32});
    end
    while (got < 32 && cyc < 200) begin
      if (r_ok) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL drain_extra got %h exp none", rdata); end
        else begin
          e = exp_q.pop_front();
          if (rdata !== e) begin errors++; $display("FAIL drain_data got %h exp %h", rdata, e); end
        end
        got++;
      end
      r_en = (issued < 32) && !r_empty;
      if (r_en) issued++;
      @(posedge rclk); #1; cyc++;
    end
    r_en = 0;
    checks++;
    if (got != 32) begin errors++; $display("FAIL drain_timeout got %0d words exp 32", got); end
    checks++;
    if ({r_empty, r_ok, r_udf, ruse, rdata} !== {1'b1, 1'b0, 1'b0, 6'd0, 8'd31}) begin
      errors++; $display("FAIL drain_end got %b exp %b", {r_empty, r_ok, r_udf, ruse, rdata}, {3'b100, 6'd0, 8'd31});
    end
    r_en = 1;
    @(posedge rclk); #1;
    r_en = 0;
    checks++;
    if ({r_udf, r_ok, rdata} !== {1'b1, 1'b0, 8'd31}) begin
      errors++; $display("FAIL underflow got %b exp %b", {r_udf, r_ok, rdata}, {2'b10, 8'd31});
    end
    repeat (5) @(posedge wclk); #1;
    checks++;
    if ({w_full, wuse} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL drain_wr got %b exp %b", {w_full, wuse}, 7'd0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] nxt, e;
    bit wdone, full_seen;
    int cyc;
    nxt = 0; wdone = 0; full_seen = 0; cyc = 0;
    fork
      begin
        @(posedge wclk); #1;
        repeat (200) begin
          w_en = 1; wdata = nxt;
          if (w_full) full_seen = 1;
          else begin exp_q.push_back(nxt); nxt++; end
          @(posedge wclk); #1;
        end
        w_en = 0; wdone = 1;
      end
      begin
        @(posedge rclk); #1;
        while (!(wdone && exp_q.size() == 0) && cyc < 1000) begin
          if (r_ok) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got %h exp none", rdata); end
            else begin
              e = exp_q.pop_front();
              if (rdata !== e) begin errors++; $display("FAIL b2b_data got %h exp %h", rdata, e); end
            end
          end
          r_en = 1;
          @(posedge rclk); #1; cyc++;
        end
        r_en = 0;
      end
    join
    checks++;
    if (cyc >= 1000) begin errors++; $display("FAIL b2b_timeout got %0d left exp 0", exp_q.size()); end
    @(posedge rclk); #1;
    checks++;
    if ({r_ok, r_empty} !== 2'b01) begin errors++; $display("FAIL b2b_end got %b exp 01", {r_ok, r_empty}); end
    checks++;
    if ({full_seen, nxt} !== {1'b0, 8'd200}) begin
      errors++; $display("FAIL b2b_accept got full=%b n=%0d exp full=0 n=200", full_seen, nxt);
    end
  endtask

  task automatic test_fwft;
    bit seen;
    seen = 0;
    @(posedge wclk); #1;
    w_en_f = 1; wdata_f = 8'h5A;
    @(posedge wclk); #1;
    w_en_f = 0;
    for (int k = 0; k < SS + 2 && !seen; k++) begin
      @(posedge rclk); #1;
      seen = !r_empty_f;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL fwft_latency got r_empty=%b exp 0 within %0d rclk", r_empty_f, SS + 2); end
    checks++;
    if ({r_empty_f, r_ok_f, rdata_f, ruse_f} !== {1'b0, 1'b1, 8'h5A, 6'd1}) begin
      errors++; $display("FAIL fwft_head got %b exp %b", {r_empty_f, r_ok_f, rdata_f, ruse_f}, {2'b01, 8'h5A, 6'd1});
    end
    r_en_f = 1;
    @(posedge rclk); #1;
    r_en_f = 0;
    checks++;
    if ({r_empty_f, r_udf_f, ruse_f} !== {1'b1, 1'b0, 6'd0}) begin
      errors++; $display("FAIL fwft_pop got %b exp %b", {r_empty_f, r_udf_f, ruse_f}, {2'b10, 6'd0});
    end
    r_en_f = 1;
    @(posedge rclk); #1;
    r_en_f = 0;
    checks++;
    if ({r_udf_f, rdata_f} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL fwft_udf got %b exp %b", {r_udf_f, rdata_f}, {1'b1, 8'h5A});
    end
  endtask

  task automatic test_fwft_burst;
    int pops, cyc;
    logic [7:0] e;
    pops = 0; cyc = 0;
    @(posedge wclk); #1;
    for (int i = 0; i < 8; i++) begin
      w_en_f = 1; wdata_f = 8'hA0 + 8'(i);
      exp_f.push_back(8'hA0 + 8'(i));
      @(posedge wclk); #1;
    end
    w_en_f = 0;
    repeat (6) @(posedge rclk); #1;
    while (pops < 8 && cyc < 50) begin
      r_en_f = !r_empty_f;
      if (r_en_f) begin
        checks++;
        e = exp_f.pop_front();
        if (rdata_f !== e) begin errors++; $display("FAIL fwft_burst_data got %h exp %h", rdata_f, e); end
        pops++;
      end
      @(posedge rclk); #1; cyc++;
    end
    r_en_f = 0;
    checks++;
    if ({cyc, r_empty_f} !== {32'd8, 1'b1}) begin
      errors++; $display("FAIL fwft_burst_rate got %0d cycles empty=%b exp 8 cycles empty=1", cyc, r_empty_f);
    end
  endtask

  task automatic test_midstream_reset;
    logic [7:0] e;
    @(posedge wclk); #1;
    for (int i = 0; i < 10; i++) begin
      w_en = 1; wdata = 8'h10 + 8'(i);
      w_en_f = 1; wdata_f = 8'h20 + 8'(i);
      @(posedge wclk); #1;
    end
    w_en = 0; w_en_f = 0;
    repeat (3) @(posedge wclk); #1;
    rst_n = 0;
    repeat (4) @(posedge wclk);
    #1 rst_n = 1;
    repeat (6) @(posedge wclk); #1;
    checks++;
    if ({w_full, w_ovf, wuse, w_full_f, w_ovf_f, wuse_f} !== 16'd0) begin
      errors++; $display("FAIL rst_mid_wr got %b exp %b", {w_full, w_ovf, wuse, w_full_f, w_ovf_f, wuse_f}, 16'd0);
    end
    @(posedge rclk); #1;
    checks++;
    if ({r_empty, r_ok, r_udf, ruse, rdata} !== {1'b1, 1'b0, 1'b0, 6'd0, 8'd0}) begin
      errors++; $display("FAIL rst_mid_rd got %b exp %b", {r_empty, r_ok, r_udf, ruse, rdata}, {3'b100, 14'd0});
    end
    checks++;
    if ({r_empty_f, r_udf_f, ruse_f} !== {1'b1, 1'b0, 6'd0}) begin
      errors++; $display("FAIL rst_mid_rd_fwft got %b exp %b", {r_empty_f, r_udf_f, ruse_f}, {2'b10, 6'd0});
    end
    exp_q.delete(); exp_f.delete();
    @(posedge wclk); #1;
    w_en = 1; wdata = 8'h77; exp_q.push_back(8'h77);
    w_en_f = 1; wdata_f = 8'h88; exp_f.push_back(8'h88);
    @(posedge wclk); #1;
    w_en = 0; w_en_f = 0;
    repeat (6) @(posedge rclk); #1;
    e = exp_f.pop_front();
    checks++;
    if ({r_empty_f, rdata_f} !== {1'b0, e}) begin
      errors++; $display("FAIL rst_post_fwft got %b exp %b", {r_empty_f, rdata_f}, {1'b0, e});
    end
    r_en = 1;
    @(posedge rclk); #1;
    r_en = 0;
    e = exp_q.pop_front();
    checks++;
    if ({r_ok, rdata} !== {1'b1, e}) begin
      errors++; $display("FAIL rst_post_std got %b exp %b", {r_ok, rdata}, {1'b1, e});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_fwft_burst();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
